// File: rtl/flit_axis_receiver.sv
// NoC ejection endpoint: buffers incoming flits in a credit-backed FIFO and
// reassembles SERIALIZATION_FACTOR flits into one AXI-Stream beat.
module flit_axis_receiver #(
   parameter int unsigned TDATA_WIDTH          = 512,
   parameter int unsigned DEST_WIDTH           = 6,
   parameter int unsigned SERIALIZATION_FACTOR = 4,
   parameter int unsigned FLIT_BUFFER_DEPTH    = 4
) (
   input  logic                                      clk,
   input  logic                                      rst_n,
   input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0] data_in,
   input  logic [DEST_WIDTH-1:0]                     dest_in,
   input  logic                                      is_tail_in,
   input  logic                                      send_in,
   output logic                                      credit_out,
   output logic                                      axis_tvalid,
   input  logic                                      axis_tready,
   output logic [TDATA_WIDTH-1:0]                    axis_tdata,
   output logic                                      axis_tlast,
   output logic [DEST_WIDTH-1:0]                     axis_tdest,
   output logic                                      overflow
);
   localparam int unsigned FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
   localparam int unsigned PTR_W      = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
   localparam int unsigned OCC_W      = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int unsigned CNT_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
   localparam int unsigned ENT_W      = FLIT_WIDTH + DEST_WIDTH + 1;

   typedef enum logic {FILL, HOLD} state_e;

   state_e                 state_q, state_d;
   logic [ENT_W-1:0]       mem_q [FLIT_BUFFER_DEPTH];
   logic [ENT_W-1:0]       mem_d [FLIT_BUFFER_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [DEST_WIDTH-1:0]  tdest_q, tdest_d;
   logic                   tlast_q, tlast_d;
   logic                   tvalid_q, tvalid_d;
   logic                   credit_q, credit_d;
   logic                   overflow_q, overflow_d;

   logic                   full_c, empty_c, push_c, pop_c;
   logic [ENT_W-1:0]       head_c;
   logic [FLIT_WIDTH-1:0]  head_data_c;
   logic [DEST_WIDTH-1:0]  head_dest_c;
   logic                   head_tail_c;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FLIT_BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_c      = (occ_q == OCC_W'(FLIT_BUFFER_DEPTH));
   assign empty_c     = (occ_q == '0);
   assign push_c      = send_in & ~full_c;
   assign head_c      = mem_q[rd_ptr_q];
   assign head_data_c = head_c[ENT_W-1 -: FLIT_WIDTH];
   assign head_dest_c = head_c[DEST_WIDTH:1];
   assign head_tail_c = head_c[0];

   // Beat assembly FSM; a handshake in HOLD immediately starts the next beat.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tdata_d  = tdata_q;
      tdest_d  = tdest_q;
      tlast_d  = tlast_q;
      tvalid_d = tvalid_q;
      pop_c    = 1'b0;
      if (state_q == HOLD && axis_tready) begin
         tvalid_d = 1'b0;
         state_d  = FILL;
      end
      if ((state_q == FILL || axis_tready) && !empty_c) begin
         pop_c = 1'b1;
         if (cnt_q == '0) begin
            tdata_d = '0;
            tdest_d = head_dest_c;
         end
         for (int unsigned k = 0; k < SERIALIZATION_FACTOR; k++) begin
            if (CNT_W'(k) == cnt_q) tdata_d[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data_c;
         end
         if (cnt_q == CNT_W'(SERIALIZATION_FACTOR - 1) || head_tail_c) begin
            cnt_d    = '0;
            tvalid_d = 1'b1;
            tlast_d  = head_tail_c;
            state_d  = HOLD;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // FIFO bookkeeping, credit return and sticky overflow.
   always_comb begin
      mem_d = mem_q;
      if (push_c) mem_d[wr_ptr_q] = {data_in, dest_in, is_tail_in};
      wr_ptr_d   = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop_c ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      occ_d      = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
      credit_d   = pop_c;
      overflow_d = overflow_q | (send_in & full_c);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= FILL;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         cnt_q      <= '0;
         tdata_q    <= '0;
         tdest_q    <= '0;
         tlast_q    <= 1'b0;
         tvalid_q   <= 1'b0;
         credit_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
         cnt_q      <= cnt_d;
         tdata_q    <= tdata_d;
         tdest_q    <= tdest_d;
         tlast_q    <= tlast_d;
         tvalid_q   <= tvalid_d;
         credit_q   <= credit_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign credit_out  = credit_q;
   assign axis_tvalid = tvalid_q;
   assign axis_tdata  = tdata_q;
   assign axis_tlast  = tlast_q;
   assign axis_tdest  = tdest_q;
   assign overflow    = overflow_q;
endmodule
